// File: rtl/seg_readback.sv
`timescale 1ns/1ps
// Read-back checker: decodes the two 7-segment drive buses back to hex/DP/blank/err once the pair is stable.
// Latency: with inputs constant from edge 0, the outputs and locked update on edge STABLE_CYCLES+2.
// Backpressure: none. The block only observes the display drive and never stalls it.
module seg_readback #(
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] seg_led_1,
    input  logic [8:0] seg_led_2,
    output logic [3:0] hex_1,
    output logic [3:0] hex_2,
    output logic       dp_1,
    output logic       dp_2,
    output logic       blank_1,
    output logic       blank_2,
    output logic       err_1,
    output logic       err_2,
    output logic       locked,
    output logic       update
);

    // Decoded view of one digit; the field order is also the compare order for update.
    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
        logic       err;
    } digit_t;

    typedef enum logic {
        WAIT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

    // A blanked digit reports only DP. A lit digit with an unknown pattern reports err.
    // DP never takes part in the pattern match.
    function automatic digit_t decode(input logic [8:0] seg);
        digit_t d;
        d.hex   = 4'h0;
        d.dp    = seg[7];
        d.blank = seg[8];
        d.err   = 1'b0;
        if (!seg[8]) begin
            case (seg[6:0])
                7'h3f:   d.hex = 4'h0;
                7'h06:   d.hex = 4'h1;
                7'h5b:   d.hex = 4'h2;
                7'h4f:   d.hex = 4'h3;
                7'h66:   d.hex = 4'h4;
                7'h6d:   d.hex = 4'h5;
                7'h7d:   d.hex = 4'h6;
                7'h07:   d.hex = 4'h7;
                7'h7f:   d.hex = 4'h8;
                7'h6f:   d.hex = 4'h9;
                7'h77:   d.hex = 4'ha;
                7'h7c:   d.hex = 4'hb;
                7'h39:   d.hex = 4'hc;
                7'h5e:   d.hex = 4'hd;
                7'h79:   d.hex = 4'he;
                7'h71:   d.hex = 4'hf;
                default: d.err = 1'b1;
            endcase
        end
        return d;
    endfunction

    logic [17:0] s_reg;
    logic [17:0] p_reg;
    logic [7:0]  cnt;
    logic        first_lock;
    state_t      state;
    logic        eq;
    digit_t      new_1;
    digit_t      new_2;
    digit_t      held_1;
    digit_t      held_2;

    assign eq     = (s_reg == p_reg);
    assign new_1  = decode(s_reg[8:0]);
    assign new_2  = decode(s_reg[17:9]);
    assign held_1 = '{hex: hex_1, dp: dp_1, blank: blank_1, err: err_1};
    assign held_2 = '{hex: hex_2, dp: dp_2, blank: blank_2, err: err_2};

    // Two-deep sample pipeline; stability is judged on the registered copies only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= '0;
            p_reg <= '0;
        end else begin
            s_reg <= {seg_led_2, seg_led_1};
            p_reg <= s_reg;
        end
    end

    // Stability counter, lock FSM and registered outputs. A mismatch always wins over a threshold hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            state      <= WAIT;
            first_lock <= 1'b1;
            hex_1      <= '0;
            hex_2      <= '0;
            dp_1       <= 1'b0;
            dp_2       <= 1'b0;
            blank_1    <= 1'b0;
            blank_2    <= 1'b0;
            err_1      <= 1'b0;
            err_2      <= 1'b0;
            locked     <= 1'b0;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            if (!eq) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
            case (state)
                WAIT: begin
                    if (eq && (cnt == CNT_HIT)) begin
                        state      <= LOCK;
                        locked     <= 1'b1;
                        first_lock <= 1'b0;
                        update     <= first_lock || (new_1 != held_1) || (new_2 != held_2);
                        hex_1      <= new_1.hex;
                        dp_1       <= new_1.dp;
                        blank_1    <= new_1.blank;
                        err_1      <= new_1.err;
                        hex_2      <= new_2.hex;
                        dp_2       <= new_2.dp;
                        blank_2    <= new_2.blank;
                        err_2      <= new_2.err;
                    end
                end
                LOCK: begin
                    if (!eq) begin
                        state  <= WAIT;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= WAIT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_readback.sv
`timescale 1ns/1ps
// Bench for seg_readback: directed vectors plus randomized traffic against a behavioural model.
// Latency: the model follows the DUT cycle by cycle and is compared on every falling edge.
// Backpressure: not applicable.
module tb_seg_readback;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] seg_led_1 = 9'h000;
    logic [8:0] seg_led_2 = 9'h000;
    logic [3:0] hex_1;
    logic [3:0] hex_2;
    logic       dp_1;
    logic       dp_2;
    logic       blank_1;
    logic       blank_2;
    logic       err_1;
    logic       err_2;
    logic       locked;
    logic       update;

    int chk = 0;
    int fails = 0;
    int upd_cnt = 0;

    seg_readback #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .seg_led_1(seg_led_1), .seg_led_2(seg_led_2),
        .hex_1(hex_1), .hex_2(hex_2), .dp_1(dp_1), .dp_2(dp_2),
        .blank_1(blank_1), .blank_2(blank_2), .err_1(err_1), .err_2(err_2),
        .locked(locked), .update(update)
    );

    always #5 clk = ~clk;

    // Segment patterns for hex 0..F, index = value.
    logic [6:0] codes [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                               7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    // Reference decode, result packed as {hex, dp, blank, err}.
    function automatic logic [6:0] mdec(input logic [8:0] seg);
        if (seg[8]) return {4'h0, seg[7], 1'b1, 1'b0};
        for (int i = 0; i < 16; i++)
            if (codes[i] == seg[6:0]) return {4'(i), seg[7], 2'b00};
        return {4'h0, seg[7], 2'b01};
    endfunction

    // Behavioural model: counts consecutive edges on which the sampled pair repeated.
    logic [17:0] m_s = '0;
    logic [17:0] m_p = '0;
    int          m_run = 0;
    bit          m_lock = 1'b0;
    bit          m_first = 1'b1;
    bit          m_upd = 1'b0;
    bit          m_eq;
    logic [6:0]  m_d1 = '0;
    logic [6:0]  m_d2 = '0;
    logic [6:0]  n1;
    logic [6:0]  n2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s = '0; m_p = '0; m_run = 0; m_lock = 1'b0; m_first = 1'b1;
            m_upd = 1'b0; m_d1 = '0; m_d2 = '0;
        end else begin
            m_eq  = (m_s == m_p);
            m_upd = 1'b0;
            if (m_lock) begin
                if (!m_eq) begin
                    m_lock = 1'b0;
                    m_run  = 0;
                end
            end else if (m_eq) begin
                m_run = m_run + 1;
                if (m_run == S) begin
                    n1 = mdec(m_s[8:0]);
                    n2 = mdec(m_s[17:9]);
                    m_upd   = m_first || (n1 != m_d1) || (n2 != m_d2);
                    m_d1    = n1;
                    m_d2    = n2;
                    m_lock  = 1'b1;
                    m_first = 1'b0;
                end
            end else begin
                m_run = 0;
            end
            m_p = m_s;
            m_s = {seg_led_2, seg_led_1};
        end
    end

    logic [15:0] dut_vec;
    assign dut_vec = {hex_1, dp_1, blank_1, err_1, hex_2, dp_2, blank_2, err_2, locked, update};

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk++;
        if (dut_vec !== {m_d1, m_d2, m_lock, m_upd}) begin
            fails++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, dut_vec, {m_d1, m_d2, m_lock, m_upd});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One clock: sample 2ns after the rising edge, where inputs are also driven.
    task automatic step();
        @(posedge clk);
        #2;
        if (update) upd_cnt++;
    endtask

    typedef struct {
        logic [8:0] s1;
        logic [8:0] s2;
        logic [6:0] d1;
        logic [6:0] d2;
        int         upd;
    } vec_t;

    vec_t vt [20];
    int   lock_seen;
    logic [8:0] cur1;
    logic [8:0] cur2;

    initial begin
        vt[0]  = '{9'h07e, 9'h0ef, {4'h0, 3'b001}, {4'h9, 3'b100}, 1};
        vt[1]  = '{9'h07e, 9'h13f, {4'h0, 3'b001}, {4'h0, 3'b010}, 1};
        for (int i = 0; i < 16; i++)
            vt[2+i] = '{{2'b00, codes[i]}, 9'h03f, {4'(i), 3'b000}, {4'h0, 3'b000}, 1};
        vt[18] = '{9'h000, 9'h000, {4'h0, 3'b001}, {4'h0, 3'b001}, 1};
        vt[19] = '{9'h086, 9'h1ff, {4'h1, 3'b100}, {4'h0, 3'b110}, 1};

        // Reset state, then first lock at edge 10 after release.
        seg_led_1 = 9'h006;
        seg_led_2 = 9'h03f;
        repeat (2) step();
        check("reset_outputs", 32'(dut_vec), 32'h0);
        rst = 1'b0;
        upd_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 9)  check("t1_not_locked_e9", 32'(locked), 32'h0);
            if (k == 10) begin
                check("t1_locked_e10", 32'(locked), 32'h1);
                check("t1_update_e10", 32'(update), 32'h1);
                check("t1_hex1", 32'(hex_1), 32'h1);
                check("t1_hex2", 32'(hex_2), 32'h0);
            end
            if (k == 11) check("t1_update_e11", 32'(update), 32'h0);
        end
        check("t1_upd_count", 32'(upd_cnt), 32'h1);

        // Three-cycle glitch, then relock to identical values: no update.
        upd_cnt = 0;
        seg_led_1 = 9'h05b;
        step();
        step();
        check("t2_unlock", 32'(locked), 32'h0);
        check("t2_hex1_held", 32'(hex_1), 32'h1);
        step();
        seg_led_1 = 9'h006;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 9)  check("t2_not_locked_e9", 32'(locked), 32'h0);
            if (k == 10) check("t2_relock_e10", 32'(locked), 32'h1);
        end
        check("t2_hex1", 32'(hex_1), 32'h1);
        check("t2_no_update", 32'(upd_cnt), 32'h0);

        // Table-driven vectors: error, blank, full sweep, DP cases.
        for (int i = 0; i < 20; i++) begin
            seg_led_1 = vt[i].s1;
            seg_led_2 = vt[i].s2;
            upd_cnt = 0;
            repeat (12) step();
            check($sformatf("vec%0d_out", i), 32'(dut_vec), 32'({vt[i].d1, vt[i].d2, 1'b1, 1'b0}));
            check($sformatf("vec%0d_upd", i), 32'(upd_cnt), 32'(vt[i].upd));
        end

        // One-cycle holds never lock and leave the held values alone.
        upd_cnt = 0;
        lock_seen = 0;
        seg_led_2 = 9'h03f;
        for (int i = 0; i < 48; i++) begin
            seg_led_1 = {2'b00, codes[i % 16]};
            step();
            if (i >= 2 && locked) lock_seen++;
        end
        check("fast_no_lock", 32'(lock_seen), 32'h0);
        check("fast_no_update", 32'(upd_cnt), 32'h0);
        check("fast_held", 32'(dut_vec[15:2]), 32'({vt[19].d1, vt[19].d2}));

        // Reset while settling; the next lock pulses update even with all-zero values.
        seg_led_1 = 9'h03f;
        seg_led_2 = 9'h03f;
        repeat (5) step();
        rst = 1'b1;
        step();
        check("t6_reset_clear", 32'(dut_vec), 32'h0);
        step();
        check("t6_reset_hold", 32'(dut_vec), 32'h0);
        rst = 1'b0;
        upd_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) check("t6_not_locked_e9", 32'(locked), 32'h0);
        end
        check("t6_locked", 32'(locked), 32'h1);
        check("t6_update", 32'(update), 32'h1);
        check("t6_hex", 32'({hex_1, hex_2}), 32'h0);

        // Randomized traffic; the falling-edge checker compares every cycle.
        cur1 = 9'h03f;
        cur2 = 9'h03f;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: cur1 = {2'b00, codes[$urandom_range(0, 15)]};
                1: cur2 = {1'b0, 1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
                2: begin
                    cur1 = 9'($urandom);
                    cur2 = 9'($urandom);
                end
                default: ;
            endcase
            seg_led_1 = cur1;
            seg_led_2 = cur2;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 13)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

endmodule
